// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if
//
// Purpose: groups every non-clock/reset signal of the pipeline sequencer
// into one bundle so the control unit and the sequencer share one port.
//
// Port summary (directions seen from the slave, i.e. the sequencer):
//   inputs : clk_enable, microcode_s0, instruction_data_si, data_dep,
//            branch_take, jmp_addr, mem_op, mem_ack
//   outputs: pc, pc_s0, ret_addr, microcode_sn, instruction_data_sn,
//            valid_sn, blk_s0, freeze
// The master modport is the surrounding core (or a testbench) driving it.
interface pipeline_sequencer_if #(
    parameter int PC_WIDTH   = 30,
    parameter int MC_WIDTH   = 25,
    parameter int ID_WIDTH   = 25,
    parameter int NUM_STAGES = 4
);
    logic                             clk_enable;
    logic [MC_WIDTH-1:0]              microcode_s0;
    logic [ID_WIDTH-1:0]              instruction_data_si;
    logic                             data_dep;
    logic                             branch_take;
    logic [PC_WIDTH-1:0]              jmp_addr;
    logic                             mem_op;
    logic                             mem_ack;

    logic [PC_WIDTH-1:0]              pc;
    logic [PC_WIDTH-1:0]              pc_s0;
    logic [PC_WIDTH-1:0]              ret_addr;
    logic [(NUM_STAGES-1)*MC_WIDTH-1:0] microcode_sn;
    logic [NUM_STAGES*ID_WIDTH-1:0]   instruction_data_sn;
    logic [NUM_STAGES-2:0]            valid_sn;
    logic                             blk_s0;
    logic                             freeze;

    modport master (
        output clk_enable, microcode_s0, instruction_data_si, data_dep,
               branch_take, jmp_addr, mem_op, mem_ack,
        input  pc, pc_s0, ret_addr, microcode_sn, instruction_data_sn,
               valid_sn, blk_s0, freeze
    );

    modport slave (
        input  clk_enable, microcode_s0, instruction_data_si, data_dep,
               branch_take, jmp_addr, mem_op, mem_ack,
        output pc, pc_s0, ret_addr, microcode_sn, instruction_data_sn,
               valid_sn, blk_s0, freeze
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
//
// Purpose: sequences a NUM_STAGES-deep RISC-V execute pipeline. Generates the
// fetch PC, carries microcode / instruction data / PC / valid down the stages,
// inserts bubbles after taken branches and data dependencies, and freezes the
// whole pipeline while a memory access at MEM_STAGE waits for its ack.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - pipeline_sequencer_if.slave carrying all control inputs
//          (clk_enable, microcode_s0, instruction_data_si, data_dep,
//          branch_take, jmp_addr, mem_op, mem_ack) and all outputs
//          (pc, pc_s0, ret_addr, microcode_sn, instruction_data_sn,
//          valid_sn, blk_s0, freeze).
module pipeline_sequencer #(
    parameter int                PC_WIDTH       = 30,
    parameter int                MC_WIDTH       = 25,
    parameter int                ID_WIDTH       = 25,
    parameter int                NUM_STAGES     = 4,
    parameter int                MEM_STAGE      = 2,
    parameter int                BRANCH_PENALTY = 3,
    parameter int                DEP_PENALTY    = 3,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_sequencer_if.slave  bus
);

    localparam int MAX_PENALTY = (BRANCH_PENALTY > DEP_PENALTY) ? BRANCH_PENALTY : DEP_PENALTY;
    localparam int BW          = $clog2(MAX_PENALTY + 1);

    localparam logic [BW-1:0] BRANCH_RELOAD = BW'(BRANCH_PENALTY - 1);
    localparam logic [BW-1:0] DEP_RELOAD    = BW'(DEP_PENALTY - 1);

    // Fetch PC and its delay chain: pc -> pc_si -> pc_s0 -> pc_s1 (ret_addr)
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_si_q;
    logic [PC_WIDTH-1:0] pc_s0_q;
    logic [PC_WIDTH-1:0] pc_s1_q;

    // Remaining bubble cycles after the one that started the window
    logic [BW-1:0] bub_cnt;

    // Stage payloads; index 1 (or 0) sits at the LSBs once flattened
    logic [NUM_STAGES-1:1][MC_WIDTH-1:0] mc_q;
    logic [NUM_STAGES-1:0][ID_WIDTH-1:0] id_q;
    logic [NUM_STAGES-1:1]               valid_q;

    logic                freeze;
    logic                dep_ok;
    logic                blk_s0;
    logic                adv;
    logic [PC_WIDTH-1:0] pc_next;
    logic [BW-1:0]       bub_next;

    // Hazard decode and next-state selection. A branch outranks a dependency,
    // and a dependency is only honoured outside a bubble window because s0 is
    // already being discarded inside one.
    always_comb begin
        freeze   = bus.mem_op & ~bus.mem_ack & valid_q[MEM_STAGE];
        dep_ok   = bus.data_dep & (bub_cnt == '0);
        blk_s0   = bus.branch_take | dep_ok | (bub_cnt != '0);
        adv      = bus.clk_enable & ~rst & ~freeze;

        pc_next  = pc_q + PC_WIDTH'(1);
        bub_next = (bub_cnt != '0) ? bub_cnt - BW'(1) : bub_cnt;

        if (bus.branch_take) begin
            pc_next  = bus.jmp_addr;
            bub_next = BRANCH_RELOAD;
        end else if (dep_ok) begin
            // Re-fetch the instruction that is being bubbled out of s0
            pc_next  = pc_s0_q;
            bub_next = DEP_RELOAD;
        end
    end

    // State register: reset wins over freeze and bubbles; otherwise every
    // register moves together only when the pipeline advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            pc_si_q <= RESET_PC;
            pc_s0_q <= RESET_PC;
            pc_s1_q <= RESET_PC;
            bub_cnt <= '0;
            mc_q    <= '0;
            id_q    <= '0;
            valid_q <= '0;
        end else if (adv) begin
            pc_q    <= pc_next;
            pc_si_q <= pc_q;
            pc_s0_q <= pc_si_q;
            pc_s1_q <= pc_s0_q;
            bub_cnt <= bub_next;

            id_q[0] <= bus.instruction_data_si;

            if (blk_s0) begin
                mc_q[1]    <= '0;
                id_q[1]    <= '0;
                valid_q[1] <= 1'b0;
            end else begin
                mc_q[1]    <= bus.microcode_s0;
                id_q[1]    <= id_q[0];
                valid_q[1] <= 1'b1;
            end

            for (int k = 2; k < NUM_STAGES; k++) begin
                mc_q[k]    <= mc_q[k-1];
                id_q[k]    <= id_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    // Output drive: everything registered except freeze and blk_s0
    always_comb begin
        bus.pc                  = pc_q;
        bus.pc_s0               = pc_s0_q;
        bus.ret_addr            = pc_s1_q;
        bus.microcode_sn        = mc_q;
        bus.instruction_data_sn = id_q;
        bus.valid_sn            = valid_q;
        bus.blk_s0              = blk_s0;
        bus.freeze              = freeze;
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer
//
// Purpose: directed, self-checking bench for pipeline_sequencer with
// RESET_PC = 0x100 and default widths/penalties. Walks through reset,
// plain fill, branches, dependencies, memory freeze, reset during a frozen
// bubble window, clock-enable hold and PC wrap-around, comparing against
// hand-computed values.
//
// Ports: none (top-level bench).
module tb_pipeline_sequencer;

    localparam int PCW = 30;
    localparam int MCW = 25;
    localparam int IDW = 25;
    localparam int NS  = 4;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    pipeline_sequencer_if #(
        .PC_WIDTH  (PCW),
        .MC_WIDTH  (MCW),
        .ID_WIDTH  (IDW),
        .NUM_STAGES(NS)
    ) bus ();

    pipeline_sequencer #(
        .PC_WIDTH      (PCW),
        .MC_WIDTH      (MCW),
        .ID_WIDTH      (IDW),
        .NUM_STAGES    (NS),
        .MEM_STAGE     (2),
        .BRANCH_PENALTY(3),
        .DEP_PENALTY   (3),
        .RESET_PC      (30'h100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive every input, then settle before any check in this cycle
    task automatic applyStimulus(input logic r, input logic ce, input logic br,
                                 input logic [PCW-1:0] ja, input logic dep,
                                 input logic mop, input logic mack,
                                 input logic [MCW-1:0] mc, input logic [IDW-1:0] id);
        rst                     = r;
        bus.clk_enable          = ce;
        bus.branch_take         = br;
        bus.jmp_addr            = ja;
        bus.data_dep            = dep;
        bus.mem_op              = mop;
        bus.mem_ack             = mack;
        bus.microcode_s0        = mc;
        bus.instruction_data_si = id;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Linear directed sequence; cN comments name the cycle after reset
    initial begin
        checks = 0;
        fails  = 0;
        $display("[TB] start");

        // Reset with junk on the data inputs
        applyStimulus(1, 1, 0, '0, 0, 0, 0, 25'h1ABC, 25'h1DEF);
        tick();
        tick();
        checkOutput("rst_pc",       bus.pc, 30'h100);
        checkOutput("rst_pc_s0",    bus.pc_s0, 30'h100);
        checkOutput("rst_ret",      bus.ret_addr, 30'h100);
        checkOutput("rst_mc",       bus.microcode_sn, '0);
        checkOutput("rst_id",       bus.instruction_data_sn, '0);
        checkOutput("rst_valid",    bus.valid_sn, '0);
        checkOutput("rst_blk",      bus.blk_s0, 0);
        checkOutput("rst_freeze",   bus.freeze, 0);
        checkOutput("rst_bub",      dut.bub_cnt, 0);

        // c0..c5: hazard-free fill
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h11, 25'h21);
        checkOutput("c0_pc",    bus.pc, 30'h100);
        checkOutput("c0_valid", bus.valid_sn, 3'b000);
        tick();
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h12, 25'h22);
        checkOutput("c1_pc",    bus.pc, 30'h101);
        checkOutput("c1_valid", bus.valid_sn, 3'b001);
        checkOutput("c1_mc",    bus.microcode_sn, {25'h0, 25'h0, 25'h11});
        tick();
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h13, 25'h23);
        checkOutput("c2_pc",    bus.pc, 30'h102);
        checkOutput("c2_valid", bus.valid_sn, 3'b011);
        checkOutput("c2_mc",    bus.microcode_sn, {25'h0, 25'h11, 25'h12});
        checkOutput("c2_pc_s0", bus.pc_s0, 30'h100);
        tick();
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h14, 25'h24);
        checkOutput("c3_pc",    bus.pc, 30'h103);
        checkOutput("c3_valid", bus.valid_sn, 3'b111);
        checkOutput("c3_mc",    bus.microcode_sn, {25'h11, 25'h12, 25'h13});
        checkOutput("c3_id",    bus.instruction_data_sn, {25'h0, 25'h21, 25'h22, 25'h23});
        checkOutput("c3_pc_s0", bus.pc_s0, 30'h101);
        checkOutput("c3_ret",   bus.ret_addr, 30'h100);
        tick();
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h15, 25'h25);
        checkOutput("c4_pc",  bus.pc, 30'h104);
        checkOutput("c4_mc",  bus.microcode_sn, {25'h12, 25'h13, 25'h14});
        checkOutput("c4_id",  bus.instruction_data_sn, {25'h21, 25'h22, 25'h23, 25'h24});
        checkOutput("c4_ret", bus.ret_addr, 30'h101);
        tick();

        // c5: branch to 0x10
        applyStimulus(0, 1, 1, 30'h10, 0, 0, 0, 25'h16, 25'h26);
        checkOutput("c5_pc",  bus.pc, 30'h105);
        checkOutput("c5_mc",  bus.microcode_sn, {25'h13, 25'h14, 25'h15});
        checkOutput("c5_ret", bus.ret_addr, 30'h102);
        checkOutput("c5_blk", bus.blk_s0, 1);
        tick();

        // c6: at pc=0x10 branch again to 0x40 (reload inside window)
        applyStimulus(0, 1, 1, 30'h40, 0, 0, 0, 25'h55, 25'h0);
        checkOutput("c6_pc",    bus.pc, 30'h10);
        checkOutput("c6_valid", bus.valid_sn, 3'b110);
        checkOutput("c6_ret",   bus.ret_addr, 30'h103);
        checkOutput("c6_blk",   bus.blk_s0, 1);
        checkOutput("c6_bub",   dut.bub_cnt, 2);
        tick();
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h55, 25'h0);
        checkOutput("c7_pc",    bus.pc, 30'h40);
        checkOutput("c7_valid", bus.valid_sn, 3'b100);
        checkOutput("c7_bub",   dut.bub_cnt, 2);
        checkOutput("c7_blk",   bus.blk_s0, 1);
        tick();
        checkOutput("c8_pc",    bus.pc, 30'h41);
        checkOutput("c8_valid", bus.valid_sn, 3'b000);
        checkOutput("c8_bub",   dut.bub_cnt, 1);
        checkOutput("c8_blk",   bus.blk_s0, 1);
        tick();
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h1A, 25'h0);
        checkOutput("c9_pc",    bus.pc, 30'h42);
        checkOutput("c9_valid", bus.valid_sn, 3'b000);
        checkOutput("c9_bub",   dut.bub_cnt, 0);
        checkOutput("c9_blk",   bus.blk_s0, 0);
        checkOutput("c9_pc_s0", bus.pc_s0, 30'h40);
        tick();

        // c10: target 0x40 valid in s1; branch to 0x20 to set up dependency
        applyStimulus(0, 1, 1, 30'h20, 0, 0, 0, 25'h55, 25'h0);
        checkOutput("c10_valid", bus.valid_sn, 3'b001);
        checkOutput("c10_mc_s1", bus.microcode_sn[MCW-1:0], 25'h1A);
        checkOutput("c10_ret",   bus.ret_addr, 30'h40);
        checkOutput("c10_pc",    bus.pc, 30'h43);
        tick();
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h55, 25'h0);
        checkOutput("c11_pc", bus.pc, 30'h20);
        tick();
        checkOutput("c12_pc", bus.pc, 30'h21);
        tick();

        // c13: dependency with pc_s0 = 0x20
        applyStimulus(0, 1, 0, '0, 1, 0, 0, 25'h55, 25'h0);
        checkOutput("c13_pc",    bus.pc, 30'h22);
        checkOutput("c13_pc_s0", bus.pc_s0, 30'h20);
        checkOutput("c13_bub",   dut.bub_cnt, 0);
        checkOutput("c13_blk",   bus.blk_s0, 1);
        tick();
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h55, 25'h0);
        checkOutput("c14_pc",    bus.pc, 30'h20);
        checkOutput("c14_bub",   dut.bub_cnt, 2);
        checkOutput("c14_v_s1",  bus.valid_sn[0], 0);
        tick();
        // c15: second dependency inside the window must be ignored
        applyStimulus(0, 1, 0, '0, 1, 0, 0, 25'h55, 25'h0);
        checkOutput("c15_pc",  bus.pc, 30'h21);
        checkOutput("c15_bub", dut.bub_cnt, 1);
        tick();
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h30, 25'h0);
        checkOutput("c16_pc",    bus.pc, 30'h22);
        checkOutput("c16_pc_s0", bus.pc_s0, 30'h20);
        checkOutput("c16_bub",   dut.bub_cnt, 0);
        checkOutput("c16_blk",   bus.blk_s0, 0);
        tick();

        // c17: refetched 0x20 valid in s1; branch to 0x50
        applyStimulus(0, 1, 1, 30'h50, 0, 0, 0, 25'h55, 25'h0);
        checkOutput("c17_v_s1",  bus.valid_sn[0], 1);
        checkOutput("c17_mc_s1", bus.microcode_sn[MCW-1:0], 25'h30);
        checkOutput("c17_ret",   bus.ret_addr, 30'h20);
        checkOutput("c17_pc",    bus.pc, 30'h23);
        tick();
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h55, 25'h0);
        checkOutput("c18_pc",  bus.pc, 30'h50);
        checkOutput("c18_bub", dut.bub_cnt, 2);
        tick();

        // c19: branch and dependency together while bub_cnt = 1
        applyStimulus(0, 1, 1, 30'h60, 1, 0, 0, 25'h55, 25'h0);
        checkOutput("c19_pc",    bus.pc, 30'h51);
        checkOutput("c19_pc_s0", bus.pc_s0, 30'h23);
        checkOutput("c19_bub",   dut.bub_cnt, 1);
        tick();
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h55, 25'h0);
        checkOutput("c20_pc",  bus.pc, 30'h60);
        checkOutput("c20_bub", dut.bub_cnt, 2);
        checkOutput("c20_blk", bus.blk_s0, 1);
        tick();
        checkOutput("c21_pc",  bus.pc, 30'h61);
        checkOutput("c21_blk", bus.blk_s0, 1);
        tick();
        checkOutput("c22_pc",    bus.pc, 30'h62);
        checkOutput("c22_blk",   bus.blk_s0, 0);
        checkOutput("c22_pc_s0", bus.pc_s0, 30'h60);
        tick();
        checkOutput("c23_pc",    bus.pc, 30'h63);
        checkOutput("c23_valid", bus.valid_sn, 3'b001);
        checkOutput("c23_ret",   bus.ret_addr, 30'h60);
        tick();

        // c24..c27: memory op at s2 without ack freezes everything
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, '0, 0, 1, 0, 25'h66, 25'h0);
            checkOutput("frz_freeze", bus.freeze, 1);
            checkOutput("frz_pc",     bus.pc, 30'h64);
            checkOutput("frz_ret",    bus.ret_addr, 30'h61);
            checkOutput("frz_valid",  bus.valid_sn, 3'b011);
            checkOutput("frz_mc_s1",  bus.microcode_sn[MCW-1:0], 25'h55);
            tick();
        end
        // c28: ack releases the freeze
        applyStimulus(0, 1, 0, '0, 0, 1, 1, 25'h66, 25'h0);
        checkOutput("c28_freeze", bus.freeze, 0);
        checkOutput("c28_pc",     bus.pc, 30'h64);
        tick();
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h55, 25'h0);
        checkOutput("c29_pc",    bus.pc, 30'h65);
        checkOutput("c29_valid", bus.valid_sn, 3'b111);
        checkOutput("c29_ret",   bus.ret_addr, 30'h62);
        checkOutput("c29_mc_s1", bus.microcode_sn[MCW-1:0], 25'h66);
        tick();

        // c30: mem_op rises together with mem_ack, plus branch to top of space
        applyStimulus(0, 1, 1, 30'h3FFFFFFF, 0, 1, 1, 25'h55, 25'h0);
        checkOutput("c30_freeze", bus.freeze, 0);
        checkOutput("c30_pc",     bus.pc, 30'h66);
        tick();
        // c31: freeze inside the bubble window
        applyStimulus(0, 1, 0, '0, 0, 1, 0, 25'h55, 25'h0);
        checkOutput("c31_pc",     bus.pc, 30'h3FFFFFFF);
        checkOutput("c31_valid",  bus.valid_sn, 3'b110);
        checkOutput("c31_freeze", bus.freeze, 1);
        checkOutput("c31_bub",    dut.bub_cnt, 2);
        tick();
        // c32: still frozen with bub_cnt held; reset asserted now
        applyStimulus(1, 1, 0, '0, 0, 1, 0, 25'h55, 25'h0);
        checkOutput("c32_pc",     bus.pc, 30'h3FFFFFFF);
        checkOutput("c32_bub",    dut.bub_cnt, 2);
        checkOutput("c32_freeze", bus.freeze, 1);
        tick();

        // c33: reset took effect; clock enable low for three edges
        applyStimulus(0, 0, 0, '0, 1, 1, 0, 25'h99, 25'h98);
        checkOutput("c33_pc",     bus.pc, 30'h100);
        checkOutput("c33_pc_s0",  bus.pc_s0, 30'h100);
        checkOutput("c33_ret",    bus.ret_addr, 30'h100);
        checkOutput("c33_valid",  bus.valid_sn, 3'b000);
        checkOutput("c33_mc",     bus.microcode_sn, '0);
        checkOutput("c33_bub",    dut.bub_cnt, 0);
        checkOutput("c33_freeze", bus.freeze, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("ce0_pc",    bus.pc, 30'h100);
            checkOutput("ce0_valid", bus.valid_sn, 3'b000);
            checkOutput("ce0_id",    bus.instruction_data_sn, '0);
            checkOutput("ce0_bub",   dut.bub_cnt, 0);
        end

        // Wrap-around: branch to 0x3FFFFFFF, then the next fetch is 0
        applyStimulus(0, 1, 1, 30'h3FFFFFFF, 0, 0, 0, 25'h55, 25'h0);
        tick();
        applyStimulus(0, 1, 0, '0, 0, 0, 0, 25'h55, 25'h0);
        checkOutput("wrap_top", bus.pc, 30'h3FFFFFFF);
        tick();
        checkOutput("wrap_zero", bus.pc, 30'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
